// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the synchronous FIFO: pops words, absorbs the 1-cycle read latency
// and re-presents them as a valid/ready stream via a 2-entry skid buffer. Optional: STREAM_CNT_EN.
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_rd_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef STREAM_CNT_EN
    output logic [CNT_WIDTH-1:0] xfer_cnt,
`endif
    output logic [WIDTH-1:0]     out_data
);

    logic [WIDTH-1:0] r_buf0;
    logic [WIDTH-1:0] r_buf1;
    logic             r_head;
    logic [1:0]       r_count;
    logic             r_inflight;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_pop;
    logic             w_cap;
    logic             w_slot;
    logic [2:0]       w_level;
    logic             w_rd_en;
    logic             w_head_nxt;
    logic [1:0]       w_count_nxt;
    logic [WIDTH-1:0] w_buf0_nxt;
    logic [WIDTH-1:0] w_buf1_nxt;
    logic [WIDTH-1:0] w_out_data_nxt;

    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end

    // Next-state logic: pop decision, capture slot, occupancy and the next head word.
    always_comb begin
        w_pop   = r_out_valid & out_ready;
        w_cap   = r_inflight & ~flush;
        // write slot uses the pre-pop head and count
        w_slot  = r_head ^ r_count[0];
        // occupancy after this edge; a pop is only issued if room remains for its data
        w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_rd_en = ~rst & ~flush & ~fifo_empty & (w_level <= 3'd1);

        w_buf0_nxt = r_buf0;
        w_buf1_nxt = r_buf1;
        if (w_cap) begin
            if (w_slot) begin
                w_buf1_nxt = fifo_rd_data;
            end else begin
                w_buf0_nxt = fifo_rd_data;
            end
        end else begin
            w_buf0_nxt = r_buf0;
            w_buf1_nxt = r_buf1;
        end

        if (flush) begin
            w_head_nxt  = 1'b0;
            w_count_nxt = 2'd0;
        end else begin
            w_head_nxt  = r_head ^ w_pop;
            w_count_nxt = r_count + {1'b0, w_cap} - {1'b0, w_pop};
        end

        w_out_data_nxt = w_head_nxt ? w_buf1_nxt : w_buf0_nxt;
    end

    // Buffer, pointer and registered output state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf0      <= {WIDTH{1'b0}};
            r_buf1      <= {WIDTH{1'b0}};
            r_head      <= 1'b0;
            r_count     <= 2'd0;
            r_inflight  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
        end else begin
            r_buf0      <= w_buf0_nxt;
            r_buf1      <= w_buf1_nxt;
            r_head      <= w_head_nxt;
            r_count     <= w_count_nxt;
            r_inflight  <= w_rd_en;
            r_out_valid <= (w_count_nxt != 2'd0);
            r_out_data  <= w_out_data_nxt;
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

`ifdef STREAM_CNT_EN
    logic [CNT_WIDTH-1:0] r_xfer_cnt;

    // Completed-transfer counter; only reset clears it, flush does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt <= {CNT_WIDTH{1'b0}};
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_xfer_cnt <= r_xfer_cnt;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO in front of it.
module tb_fifo_rd_stream;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 4;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             flush     = 1'b0;
    logic             out_ready = 1'b0;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             out_valid;
    logic [WIDTH-1:0] fifo_rd_data = 8'h00;
    logic [WIDTH-1:0] out_data;
`ifdef STREAM_CNT_EN
    logic [CNT_WIDTH-1:0] xfer_cnt;
`endif

    logic [WIDTH-1:0] mem [0:63];
    int wp = 0;
    int rp = 0;
    int n_vec = 0;
    int n_err = 0;
    int idx;

    fifo_rd_stream #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
`ifdef STREAM_CNT_EN
        .xfer_cnt     (xfer_cnt),
`endif
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    // FIFO read port: registered data, valid the cycle after the pop
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rp[5:0]];
            rp <= rp + 1;
        end
    end

    task automatic push(input logic [WIDTH-1:0] d);
        mem[wp[5:0]] = d;
        wp = wp + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
`ifdef STREAM_CNT_EN
        chk("rst_cnt", xfer_cnt, 0);
`endif
        rst = 1'b0;

        // streaming 0x01..0x08 with sink always ready
        next_cycle();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) push(k[7:0]);
        #1;
        for (int i = 0; i < 12; i++) begin
            chk("stream_rd_en", fifo_rd_en, (i < 8));
            chk("stream_valid", out_valid, (i >= 2 && i < 10));
            if (i >= 2 && i < 10) chk("stream_data", out_data, i - 1);
            next_cycle();
        end
`ifdef STREAM_CNT_EN
        chk("cnt_stream", xfer_cnt, 8);
`endif

        // backpressure: 10 cycles of out_ready=0, then release
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(8'hA0 + k[7:0]);
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i == 10) begin
                out_ready = 1'b1;
                #1;
            end
            chk("bp_rd_en", fifo_rd_en, (i < 2) || (i >= 10 && i <= 12));
            chk("bp_valid", out_valid, (i >= 2 && i <= 14));
            if (i >= 2 && i < 10) chk("bp_hold_data", out_data, 8'hA0);
            if (i >= 10 && i <= 14) chk("bp_data", out_data, 8'hA0 + (i - 10));
            next_cycle();
        end
`ifdef STREAM_CNT_EN
        chk("cnt_bp", xfer_cnt, 13);
`endif

        // alternating ready over 6 words
        for (int k = 0; k < 6; k++) push(8'hB0 + k[7:0]);
        idx = 0;
        for (int i = 0; i < 40 && idx < 6; i++) begin
            out_ready = i[0];
            #1;
            if (out_valid && out_ready) begin
                chk("alt_data", out_data, 8'hB0 + idx);
                idx++;
            end
            next_cycle();
        end
        chk("alt_delivered", idx, 6);
        out_ready = 1'b1;
        #1;
        chk("alt_no_extra", out_valid, 0);
`ifdef STREAM_CNT_EN
        chk("cnt_alt_wrap", xfer_cnt, 3);
`endif

        // flush with 0x22 buffered and 0x33 in flight
        next_cycle();
        out_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1;
        chk("fl_rd0", fifo_rd_en, 1);
        next_cycle();
        chk("fl_rd1", fifo_rd_en, 1);
        next_cycle();
        chk("fl_rd2", fifo_rd_en, 0);
        chk("fl_data2", out_data, 8'h11);
        next_cycle();
        out_ready = 1'b1;
        #1;
        chk("fl_rd3", fifo_rd_en, 1);
        chk("fl_data3", out_data, 8'h11);
        next_cycle();
        flush = 1'b1;
        #1;
        chk("fl_rd_in_flush", fifo_rd_en, 0);
        chk("fl_valid_in_flush", out_valid, 1);
        chk("fl_data_in_flush", out_data, 8'h22);
`ifdef STREAM_CNT_EN
        chk("cnt_before_flush", xfer_cnt, 4);
`endif
        next_cycle();
        flush = 1'b0;
        #1;
        chk("fl_valid_after", out_valid, 0);
        chk("fl_rd_after", fifo_rd_en, 1);
`ifdef STREAM_CNT_EN
        chk("cnt_after_flush", xfer_cnt, 5);
`endif
        next_cycle();
        chk("fl_valid6", out_valid, 0);
        next_cycle();
        chk("fl_valid7", out_valid, 1);
        chk("fl_next_word", out_data, 8'h44);
        next_cycle();
        chk("fl_valid8", out_valid, 0);
`ifdef STREAM_CNT_EN
        chk("cnt_end_flush", xfer_cnt, 6);
`endif

        // asynchronous reset mid-stream
        for (int k = 1; k <= 6; k++) push(8'hC0 + k[7:0]);
        #1;
        chk("rs_rd0", fifo_rd_en, 1);
        repeat (3) next_cycle();
        chk("rs_valid3", out_valid, 1);
        chk("rs_data3", out_data, 8'hC2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rs_async_valid", out_valid, 0);
        chk("rs_async_data", out_data, 0);
        chk("rs_async_rd_en", fifo_rd_en, 0);
`ifdef STREAM_CNT_EN
        chk("rs_async_cnt", xfer_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rs_resume_rd", fifo_rd_en, 1);
        repeat (2) next_cycle();
        chk("rs_resume_valid", out_valid, 1);
        chk("rs_resume_data", out_data, 8'hC5);
        next_cycle();
        chk("rs_resume_data2", out_data, 8'hC6);
        next_cycle();
        chk("rs_resume_idle", out_valid, 0);
`ifdef STREAM_CNT_EN
        chk("rs_resume_cnt", xfer_cnt, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
